// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate extraction, load-use interlock and a
// single-entry valid/ready output register feeding execute.
module decode_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              d_clk,
    input  logic              d_rst,
    input  logic              d_i_valid,
    output logic              d_i_ready,
    input  logic [31:0]       d_i_instr,
    input  logic [DWIDTH-1:0] d_i_pc,
    input  logic              d_flush,
    output logic [AWIDTH-1:0] d_addr_rs1,
    output logic [AWIDTH-1:0] d_addr_rs2,
    output logic              d_o_valid,
    input  logic              d_o_ready,
    output logic [DWIDTH-1:0] d_o_pc,
    output logic [6:0]        d_o_opcode,
    output logic [2:0]        d_o_funct3,
    output logic [6:0]        d_o_funct7,
    output logic [AWIDTH-1:0] d_o_rd,
    output logic [DWIDTH-1:0] d_o_imm,
    output logic              d_o_illegal
);

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    logic [6:0]        w_op;
    logic              w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j;
    logic              w_legal, w_uses_rs1, w_uses_rs2;
    logic [AWIDTH-1:0] w_fld_rs1, w_fld_rs2, w_fld_rd;
    logic [AWIDTH-1:0] w_rs1, w_rs2, w_rd;
    logic signed [11:0] w_imm_i, w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [20:0] w_imm_j;
    logic signed [31:0] w_imm_u;
    logic [DWIDTH-1:0] w_imm;
    logic              w_hazard, w_accept;

    logic              r_valid;
    logic [DWIDTH-1:0] r_pc;
    logic [6:0]        r_opcode;
    logic [2:0]        r_funct3;
    logic [6:0]        r_funct7;
    logic [AWIDTH-1:0] r_rd;
    logic [DWIDTH-1:0] r_imm;
    logic              r_illegal;
    logic [AWIDTH-1:0] r_rs1_hold, r_rs2_hold;

    assign w_op   = d_i_instr[6:0];
    assign w_is_r = (w_op == OP_REG);
    assign w_is_i = (w_op inside {OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYS});
    assign w_is_s = (w_op == OP_STORE);
    assign w_is_b = (w_op == OP_BR);
    assign w_is_u = (w_op inside {OP_LUI, OP_AUIPC});
    assign w_is_j = (w_op == OP_JAL);
    assign w_legal = (d_i_instr[1:0] == 2'b11) &&
                     (w_is_r || w_is_i || w_is_s || w_is_b || w_is_u || w_is_j);

    // Source usage follows the opcode alone, so unknown opcodes still read rs1.
    assign w_uses_rs1 = !(w_op inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign w_uses_rs2 = w_is_r || w_is_s || w_is_b;

    assign w_fld_rs1 = AWIDTH'(d_i_instr[19:15]);
    assign w_fld_rs2 = AWIDTH'(d_i_instr[24:20]);
    assign w_fld_rd  = AWIDTH'(d_i_instr[11:7]);
    assign w_rs1 = w_uses_rs1 ? w_fld_rs1 : '0;
    assign w_rs2 = w_uses_rs2 ? w_fld_rs2 : '0;
    assign w_rd  = (!w_legal || w_is_s || w_is_b) ? '0 : w_fld_rd;

    assign w_imm_i = d_i_instr[31:20];
    assign w_imm_s = {d_i_instr[31:25], d_i_instr[11:7]};
    assign w_imm_b = {d_i_instr[31], d_i_instr[7], d_i_instr[30:25], d_i_instr[11:8], 1'b0};
    assign w_imm_u = {d_i_instr[31:12], 12'b0};
    assign w_imm_j = {d_i_instr[31], d_i_instr[19:12], d_i_instr[20], d_i_instr[30:21], 1'b0};

    always_comb begin
        w_imm = '0;
        if (w_legal) begin
            if (w_is_i)      w_imm = DWIDTH'(w_imm_i);
            else if (w_is_s) w_imm = DWIDTH'(w_imm_s);
            else if (w_is_b) w_imm = DWIDTH'(w_imm_b);
            else if (w_is_u) w_imm = DWIDTH'(w_imm_u);
            else if (w_is_j) w_imm = DWIDTH'(w_imm_j);
        end
    end

    // Load-use interlock: the loaded value is not available until the load leaves.
    assign w_hazard = r_valid && (r_opcode == OP_LOAD) && (r_rd != '0) &&
                      ((w_uses_rs1 && (w_fld_rs1 == r_rd)) ||
                       (w_uses_rs2 && (w_fld_rs2 == r_rd)));

    assign d_i_ready = (!r_valid || d_o_ready) && !w_hazard && !d_flush;
    assign w_accept  = d_i_valid && d_i_ready;

    assign d_addr_rs1 = d_rst ? '0 : (w_accept ? w_rs1 : r_rs1_hold);
    assign d_addr_rs2 = d_rst ? '0 : (w_accept ? w_rs2 : r_rs2_hold);

    always_ff @(posedge d_clk or posedge d_rst) begin
        if (d_rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7   <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_illegal  <= 1'b0;
            r_rs1_hold <= '0;
            r_rs2_hold <= '0;
        end else if (d_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= d_i_pc;
            r_opcode   <= w_op;
            r_funct3   <= d_i_instr[14:12];
            r_funct7   <= d_i_instr[31:25];
            r_rd       <= w_rd;
            r_imm      <= w_imm;
            r_illegal  <= !w_legal;
            r_rs1_hold <= w_rs1;
            r_rs2_hold <= w_rs2;
        end else if (!r_valid || d_o_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign d_o_valid   = r_valid;
    assign d_o_pc      = r_pc;
    assign d_o_opcode  = r_opcode;
    assign d_o_funct3  = r_funct3;
    assign d_o_funct7  = r_funct7;
    assign d_o_rd      = r_rd;
    assign d_o_imm     = r_imm;
    assign d_o_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic,
// all compared against a behavioural model of the decode rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        flush = 1'b0;
    logic        o_ready = 1'b0;
    logic        i_ready, o_valid, o_illegal;
    logic [4:0]  addr_rs1, addr_rs2, o_rd;
    logic [31:0] o_pc, o_imm;
    logic [6:0]  o_opcode, o_funct7;
    logic [2:0]  o_funct3;

    always #5 clk = ~clk;

    decode_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
        .d_clk(clk), .d_rst(rst), .d_i_valid(i_valid), .d_i_ready(i_ready),
        .d_i_instr(i_instr), .d_i_pc(i_pc), .d_flush(flush),
        .d_addr_rs1(addr_rs1), .d_addr_rs2(addr_rs2),
        .d_o_valid(o_valid), .d_o_ready(o_ready), .d_o_pc(o_pc),
        .d_o_opcode(o_opcode), .d_o_funct3(o_funct3), .d_o_funct7(o_funct7),
        .d_o_rd(o_rd), .d_o_imm(o_imm), .d_o_illegal(o_illegal)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill, u1, u2;
        logic [4:0]  a1, a2;
    } dec_t;

    int checks = 0;
    int failures = 0;

    // Model state: contents of the output register and held addresses
    logic        m_valid, m_ill;
    logic [31:0] m_pc, m_imm;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd, m_h1, m_h2;
    // Predictions for the cycle currently being driven
    dec_t        p_dec;
    logic        p_acc, p_flush, p_ordy;
    logic [31:0] p_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t   d;
        byte    fmt;
        longint v;
        d.op = ins[6:0];
        d.f3 = ins[14:12];
        d.f7 = ins[31:25];
        case (d.op)
            7'h33:                             fmt = "R";
            7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: fmt = "I";
            7'h23:                             fmt = "S";
            7'h63:                             fmt = "B";
            7'h37, 7'h17:                      fmt = "U";
            7'h6F:                             fmt = "J";
            default:                           fmt = "X";
        endcase
        d.ill = (ins[1:0] != 2'b11) || (fmt == "X");
        v = 0;
        case (fmt)
            "I": begin
                v = longint'(ins[31:20]);
                if (ins[31]) v -= 4096;
            end
            "S": begin
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            "B": begin
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                    longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 8192;
            end
            "U": v = longint'(ins[31:12]) * 4096;
            "J": begin
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                    longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v -= 2097152;
            end
            default: v = 0;
        endcase
        d.imm = d.ill ? 32'h0 : 32'(v);
        d.rd  = (d.ill || fmt == "S" || fmt == "B") ? 5'd0 : ins[11:7];
        d.u1  = !(d.op == 7'h37 || d.op == 7'h17 || d.op == 7'h6F);
        d.u2  = (fmt == "R" || fmt == "S" || fmt == "B");
        d.a1  = d.u1 ? ins[19:15] : 5'd0;
        d.a2  = d.u2 ? ins[24:20] : 5'd0;
        return d;
    endfunction

    task automatic m_reset();
        m_valid = 0; m_ill = 0; m_pc = 0; m_imm = 0; m_op = 0;
        m_f7 = 0; m_f3 = 0; m_rd = 0; m_h1 = 0; m_h2 = 0;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        logic hz, rdy;
        i_valid = v; i_instr = ins; i_pc = pc; flush = fl; o_ready = ordy;
        #1;
        p_dec = ref_decode(ins);
        hz = m_valid && (m_op == 7'h03) && (m_rd != 0) &&
             ((p_dec.u1 && ins[19:15] == m_rd) || (p_dec.u2 && ins[24:20] == m_rd));
        rdy = (!m_valid || ordy) && !hz && !fl;
        p_acc = v && rdy;
        p_flush = fl; p_ordy = ordy; p_pc = pc;
        chk("i_ready", 32'(i_ready), 32'(rdy));
        chk("addr_rs1", 32'(addr_rs1), 32'(p_acc ? p_dec.a1 : m_h1));
        chk("addr_rs2", 32'(addr_rs2), 32'(p_acc ? p_dec.a2 : m_h2));
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_flush) m_valid = 0;
        else if (p_acc) begin
            m_valid = 1; m_pc = p_pc; m_op = p_dec.op; m_f3 = p_dec.f3;
            m_f7 = p_dec.f7; m_rd = p_dec.rd; m_imm = p_dec.imm; m_ill = p_dec.ill;
            m_h1 = p_dec.a1; m_h2 = p_dec.a2;
        end else if (!m_valid || p_ordy) m_valid = 0;
        #1;
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_pc", o_pc, m_pc);
        chk("o_opcode", 32'(o_opcode), 32'(m_op));
        chk("o_funct3", 32'(o_funct3), 32'(m_f3));
        chk("o_funct7", 32'(o_funct7), 32'(m_f7));
        chk("o_rd", 32'(o_rd), 32'(m_rd));
        chk("o_imm", o_imm, m_imm);
        chk("o_illegal", 32'(o_illegal), 32'(m_ill));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'h0);
        chk({tag, "_pc"}, o_pc, 32'h0);
        chk({tag, "_opcode"}, 32'(o_opcode), 32'h0);
        chk({tag, "_rd"}, 32'(o_rd), 32'h0);
        chk({tag, "_imm"}, o_imm, 32'h0);
        chk({tag, "_illegal"}, 32'(o_illegal), 32'h0);
        chk({tag, "_rs1"}, 32'(addr_rs1), 32'h0);
        chk({tag, "_rs2"}, 32'(addr_rs2), 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 14))
            0, 1, 2: w[6:0] = 7'h03;
            3:  w[6:0] = 7'h33;
            4:  w[6:0] = 7'h13;
            5:  w[6:0] = 7'h23;
            6:  w[6:0] = 7'h63;
            7:  w[6:0] = 7'h37;
            8:  w[6:0] = 7'h17;
            9:  w[6:0] = 7'h6F;
            10: w[6:0] = 7'h67;
            11: w[6:0] = 7'h0F;
            12: w[6:0] = 7'h73;
            13: w[6:0] = 7'h0B;
            default: w[1:0] = 2'($urandom_range(0, 2));
        endcase
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        w[11:7]  = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 0;

        // addi x5,x1,-3
        drive(1, 32'hFFD08293, 32'h100, 0, 1);
        chk("addi_rs1", 32'(addr_rs1), 32'd1);
        chk("addi_rs2", 32'(addr_rs2), 32'd0);
        tick();
        chk("addi_valid", 32'(o_valid), 32'd1);
        chk("addi_opcode", 32'(o_opcode), 32'h13);
        chk("addi_rd", 32'(o_rd), 32'd5);
        chk("addi_imm", o_imm, 32'hFFFFFFFD);

        // lw x6,0(x2) then add x7,x6,x1: one stall, one bubble
        drive(1, 32'h00012303, 32'h104, 0, 1);
        tick();
        drive(1, 32'h001303B3, 32'h108, 0, 1);
        chk("loaduse_stall", 32'(i_ready), 32'd0);
        tick();
        chk("loaduse_bubble", 32'(o_valid), 32'd0);
        drive(1, 32'h001303B3, 32'h108, 0, 1);
        chk("loaduse_release", 32'(i_ready), 32'd1);
        tick();
        chk("add_rd", 32'(o_rd), 32'd7);
        chk("add_valid", 32'(o_valid), 32'd1);

        // three cycles of backpressure on the add
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h00A00513, 32'h10C, 0, 0);
            chk("stall_ready", 32'(i_ready), 32'd0);
            chk("stall_rs1", 32'(addr_rs1), 32'd6);
            chk("stall_rs2", 32'(addr_rs2), 32'd1);
            tick();
            chk("stall_pc", o_pc, 32'h108);
            chk("stall_rd", 32'(o_rd), 32'd7);
        end
        drive(1, 32'h00A00513, 32'h10C, 0, 1);
        chk("stall_advance", 32'(i_ready), 32'd1);
        tick();
        chk("advance_pc", o_pc, 32'h10C);

        // flush during backpressure with an incoming instruction
        drive(1, 32'h00B00593, 32'h110, 1, 0);
        chk("flush_ready", 32'(i_ready), 32'd0);
        tick();
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_pc_held", o_pc, 32'h10C);

        // all-zero word is illegal but still accepted
        drive(1, 32'h00000000, 32'h114, 0, 1);
        chk("illegal_accept", 32'(i_ready), 32'd1);
        tick();
        chk("illegal_flag", 32'(o_illegal), 32'd1);
        chk("illegal_rd", 32'(o_rd), 32'd0);
        chk("illegal_imm", o_imm, 32'd0);
        chk("illegal_valid", 32'(o_valid), 32'd1);

        // reset pulse during a stall
        drive(1, 32'h00C00613, 32'h118, 0, 0);
        tick();
        drive(1, 32'h00C00613, 32'h118, 0, 0);
        rst = 1;
        #1;
        check_reset_state("midreset");
        m_reset();
        @(posedge clk);
        #1;
        rst = 0;
        drive(1, 32'h00C00613, 32'h118, 0, 0);
        chk("postreset_ready", 32'(i_ready), 32'd1);
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1;
                #1;
                check_reset_state("rnd_reset");
                m_reset();
                @(posedge clk);
                #1;
                rst = 0;
            end
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
